// File: rtl/instr_stream_feeder.sv
// Program memory plus fetch sequencer that streams 16-bit instructions into the
// mini RISC core's two-beat load protocol and follows the core PC for branches.
module instr_stream_feeder #(
    parameter int          AW        = 5,
    parameter logic [15:0] HALT_WORD = 16'hFFFF,
    parameter int          MAX_ISSUE = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] core_pc,
    output logic          load_en,
    output logic [6:0]    lo_data,
    output logic [7:0]    hi_data,
    output logic [AW-1:0] fetch_addr,
    output logic          busy,
    output logic          done,
    output logic [7:0]    icount,
    output logic          wr_err
);

    localparam logic [7:0] MAX_ISSUE_C = 8'(MAX_ISSUE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_BEAT_LO = 3'd2,
        S_BEAT_HI = 3'd3,
        S_EXEC    = 3'd4,
        S_PCWAIT  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t        state_r, state_s;
    logic [15:0]   mem_r [0:(1<<AW)-1];
    logic [15:0]   mem_rd_s;
    logic [15:0]   word_r, word_s;
    logic          load_en_r, load_en_s;
    logic [6:0]    lo_data_r, lo_data_s;
    logic [7:0]    hi_data_r, hi_data_s;
    logic [AW-1:0] fetch_addr_r, fetch_addr_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic [7:0]    icount_r, icount_s;
    logic          wr_err_r;

    assign mem_rd_s = mem_r[fetch_addr_r];

    // Program memory write port; writes are only accepted between runs.
    always_ff @(posedge clk) begin
        if (prog_we && !busy_r) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-output logic; outputs are registered from these values
    // so each beat appears on the wires during the cycle of its state.
    always_comb begin
        state_s      = state_r;
        word_s       = word_r;
        fetch_addr_s = fetch_addr_r;
        icount_s     = icount_r;
        load_en_s    = 1'b0;
        lo_data_s    = 7'd0;
        hi_data_s    = 8'd0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_s      = S_READ;
                    fetch_addr_s = {AW{1'b0}};
                    icount_s     = 8'd0;
                end else begin
                    state_s = state_r;
                end
            end
            S_READ: begin
                word_s = mem_rd_s;
                if (mem_rd_s == HALT_WORD) begin
                    state_s = S_DONE;
                end else if (icount_r == MAX_ISSUE_C) begin
                    state_s = S_DONE;
                end else begin
                    state_s   = S_BEAT_LO;
                    load_en_s = 1'b1;
                    lo_data_s = mem_rd_s[6:0];
                end
            end
            S_BEAT_LO: begin
                state_s   = S_BEAT_HI;
                load_en_s = 1'b1;
                hi_data_s = word_r[15:8];
            end
            S_BEAT_HI: begin
                state_s  = S_EXEC;
                icount_s = (icount_r == 8'hFF) ? icount_r : icount_r + 8'd1;
            end
            S_EXEC: begin
                state_s = S_PCWAIT;
            end
            S_PCWAIT: begin
                state_s      = S_READ;
                fetch_addr_s = core_pc;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        // stop overrides every transition, including a pending second beat.
        if (busy_r && stop) begin
            state_s      = S_DONE;
            fetch_addr_s = fetch_addr_r;
            icount_s     = icount_r;
            load_en_s    = 1'b0;
            lo_data_s    = 7'd0;
            hi_data_s    = 8'd0;
        end else begin
            state_s = state_s;
        end

        busy_s = (state_s != S_IDLE) && (state_s != S_DONE);
        done_s = (state_s == S_DONE);
    end

    // Registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_r       <= 16'd0;
            load_en_r    <= 1'b0;
            lo_data_r    <= 7'd0;
            hi_data_r    <= 8'd0;
            fetch_addr_r <= {AW{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            icount_r     <= 8'd0;
            wr_err_r     <= 1'b0;
        end else begin
            word_r       <= word_s;
            load_en_r    <= load_en_s;
            lo_data_r    <= lo_data_s;
            hi_data_r    <= hi_data_s;
            fetch_addr_r <= fetch_addr_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            icount_r     <= icount_s;
            wr_err_r     <= prog_we && busy_r;
        end
    end

    assign load_en    = load_en_r;
    assign lo_data    = lo_data_r;
    assign hi_data    = hi_data_r;
    assign fetch_addr = fetch_addr_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign icount     = icount_r;
    assign wr_err     = wr_err_r;

endmodule

// File: tb/tb_instr_stream_feeder.sv
// Directed self-checking bench for instr_stream_feeder with a scripted core PC model.
module tb_instr_stream_feeder;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst, prog_we, start, start3, stop;
    logic [AW-1:0] prog_addr, core_pc;
    logic [15:0]   prog_data;

    logic          load_en, busy, done, wr_err;
    logic [6:0]    lo_data;
    logic [7:0]    hi_data, icount;
    logic [AW-1:0] fetch_addr;

    logic          load_en3, busy3, done3, wr_err3;
    logic [6:0]    lo_data3;
    logic [7:0]    hi_data3, icount3;
    logic [AW-1:0] fetch_addr3;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] pc_seq [16];
    int            pc_n;
    logic [6:0]    lo_log [16];
    logic [7:0]    hi_log [16];
    logic [AW-1:0] addr_log [16];
    int            n_issued, le_cycles, first_le_cyc, done_cyc, idle_nz, wr_err_seen;

    instr_stream_feeder #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .stop(stop), .core_pc(core_pc),
        .load_en(load_en), .lo_data(lo_data), .hi_data(hi_data), .fetch_addr(fetch_addr),
        .busy(busy), .done(done), .icount(icount), .wr_err(wr_err)
    );

    instr_stream_feeder #(.AW(AW), .MAX_ISSUE(3)) dut3 (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start3), .stop(1'b0), .core_pc(core_pc),
        .load_en(load_en3), .lo_data(lo_data3), .hi_data(hi_data3), .fetch_addr(fetch_addr3),
        .busy(busy3), .done(done3), .icount(icount3), .wr_err(wr_err3)
    );

    always #5 clk = ~clk;

    task automatic write_mem(input logic [AW-1:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Pulse start, play the core PC script after every second beat, log beats until done.
    task automatic run(input int max_cyc);
        int   cyc;
        int   pc_idx;
        logic prev_le;
        n_issued = 0; le_cycles = 0; first_le_cyc = -1; idle_nz = 0; wr_err_seen = 0;
        pc_idx = 0; prev_le = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < max_cyc) begin
            if (wr_err) wr_err_seen++;
            if (load_en) begin
                le_cycles++;
                if (!prev_le) begin
                    if (first_le_cyc < 0) first_le_cyc = cyc;
                    if (n_issued < 16) begin
                        lo_log[n_issued]   = lo_data;
                        addr_log[n_issued] = fetch_addr;
                    end
                end else begin
                    if (n_issued < 16) hi_log[n_issued] = hi_data;
                    n_issued++;
                    if (pc_idx < pc_n) core_pc = pc_seq[pc_idx];
                    pc_idx++;
                end
            end else if (lo_data !== 7'd0 || hi_data !== 8'd0) begin
                idle_nz++;
            end
            prev_le = load_en;
            @(negedge clk);
            cyc++;
        end
        done_cyc = cyc;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL run_timeout: done=%b after %0d cycles, required 1", done, cyc); end
    endtask

    task automatic test_reset();
        rst = 1'b1; prog_we = 1'b0; start = 1'b0; start3 = 1'b0; stop = 1'b0;
        prog_addr = '0; prog_data = 16'd0; core_pc = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({load_en, lo_data, hi_data, fetch_addr, busy, done, icount, wr_err} !== 32'd0) begin
            errors++; $display("FAIL reset_outputs: got %h, required 0", {load_en, lo_data, hi_data, fetch_addr, busy, done, icount, wr_err});
        end
        checks++;
        if ({load_en3, lo_data3, hi_data3, fetch_addr3, busy3, done3, icount3, wr_err3} !== 32'd0) begin
            errors++; $display("FAIL reset_outputs3: got %h, required 0", {load_en3, lo_data3, hi_data3, fetch_addr3, busy3, done3, icount3, wr_err3});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        write_mem(5'd0, 16'h0025);
        write_mem(5'd1, 16'hFFFF);
        pc_seq[0] = 5'd1; pc_n = 1;
        run(40);
        checks++; if (n_issued !== 1) begin errors++; $display("FAIL single_issued: got %0d, required 1", n_issued); end
        checks++; if (lo_log[0] !== 7'h25) begin errors++; $display("FAIL single_lo: got %h, required 25", lo_log[0]); end
        checks++; if (hi_log[0] !== 8'h00) begin errors++; $display("FAIL single_hi: got %h, required 00", hi_log[0]); end
        checks++; if (le_cycles !== 2) begin errors++; $display("FAIL single_le_cycles: got %0d, required 2", le_cycles); end
        checks++; if (first_le_cyc !== 2) begin errors++; $display("FAIL single_first_le: got %0d, required 2", first_le_cyc); end
        checks++; if (done_cyc !== 7) begin errors++; $display("FAIL single_done_cycle: got %0d, required 7", done_cyc); end
        checks++; if (icount !== 8'd1) begin errors++; $display("FAIL single_icount: got %0d, required 1", icount); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b, required 0", busy); end
        checks++; if (idle_nz !== 0) begin errors++; $display("FAIL single_idle_data: got %0d nonzero cycles, required 0", idle_nz); end
    endtask

    task automatic test_sequential();
        write_mem(5'd0, 16'hA5C3);
        write_mem(5'd1, 16'h1234);
        write_mem(5'd2, 16'h00FF);
        write_mem(5'd3, 16'hFFFF);
        pc_seq[0] = 5'd1; pc_seq[1] = 5'd2; pc_seq[2] = 5'd3; pc_n = 3;
        run(80);
        checks++; if (n_issued !== 3) begin errors++; $display("FAIL seq_issued: got %0d, required 3", n_issued); end
        checks++; if ({addr_log[0], addr_log[1], addr_log[2]} !== {5'd0, 5'd1, 5'd2}) begin
            errors++; $display("FAIL seq_addrs: got %0d %0d %0d, required 0 1 2", addr_log[0], addr_log[1], addr_log[2]); end
        checks++; if (fetch_addr !== 5'd3) begin errors++; $display("FAIL seq_halt_addr: got %0d, required 3", fetch_addr); end
        checks++; if ({lo_log[0], lo_log[1], lo_log[2]} !== {7'h43, 7'h34, 7'h7F}) begin
            errors++; $display("FAIL seq_lo: got %h %h %h, required 43 34 7f", lo_log[0], lo_log[1], lo_log[2]); end
        checks++; if ({hi_log[0], hi_log[1], hi_log[2]} !== {8'hA5, 8'h12, 8'h00}) begin
            errors++; $display("FAIL seq_hi: got %h %h %h, required a5 12 00", hi_log[0], hi_log[1], hi_log[2]); end
        checks++; if (icount !== 8'd3) begin errors++; $display("FAIL seq_icount: got %0d, required 3", icount); end
        checks++; if (done_cyc !== 17) begin errors++; $display("FAIL seq_done_cycle: got %0d, required 17", done_cyc); end
    endtask

    task automatic test_branch();
        write_mem(5'd0, 16'h1111);
        write_mem(5'd7, 16'h2A9C);
        write_mem(5'd31, 16'h3333);
        write_mem(5'd5, 16'hFFFF);
        pc_seq[0] = 5'd7; pc_seq[1] = 5'd31; pc_seq[2] = 5'd0; pc_seq[3] = 5'd5; pc_n = 4;
        run(80);
        checks++; if (n_issued !== 4) begin errors++; $display("FAIL branch_issued: got %0d, required 4", n_issued); end
        checks++; if ({addr_log[0], addr_log[1], addr_log[2], addr_log[3]} !== {5'd0, 5'd7, 5'd31, 5'd0}) begin
            errors++; $display("FAIL branch_addrs: got %0d %0d %0d %0d, required 0 7 31 0", addr_log[0], addr_log[1], addr_log[2], addr_log[3]); end
        checks++; if ({lo_log[1], hi_log[1]} !== {7'h1C, 8'h2A}) begin
            errors++; $display("FAIL branch_target_word: got %h %h, required 1c 2a", lo_log[1], hi_log[1]); end
        checks++; if (icount !== 8'd4) begin errors++; $display("FAIL branch_icount: got %0d, required 4", icount); end
        checks++; if (wr_err_seen !== 0) begin errors++; $display("FAIL branch_wrap_err: got %0d, required 0", wr_err_seen); end
    endtask

    task automatic test_stop();
        int   lo_seen;
        logic prev;
        write_mem(5'd0, 16'h4444);
        write_mem(5'd1, 16'h5555);
        write_mem(5'd2, 16'hFFFF);
        core_pc = 5'd0; lo_seen = 0; prev = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 30 && lo_seen < 2; c++) begin
            @(negedge clk);
            if (load_en && prev) core_pc = 5'd1;
            if (load_en && !prev) lo_seen++;
            prev = load_en;
        end
        checks++; if (lo_seen !== 2 || lo_data !== 7'h55) begin
            errors++; $display("FAIL stop_second_lo: got beats=%0d lo=%h, required 2 55", lo_seen, lo_data); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++; if ({load_en, busy, done} !== 3'b001) begin
            errors++; $display("FAIL stop_done: got load_en/busy/done=%b, required 001", {load_en, busy, done}); end
        checks++; if (icount !== 8'd1) begin errors++; $display("FAIL stop_icount: got %0d, required 1", icount); end
        pc_seq[0] = 5'd1; pc_seq[1] = 5'd2; pc_n = 2;
        run(60);
        checks++; if (n_issued !== 2 || addr_log[0] !== 5'd0 || lo_log[0] !== 7'h44) begin
            errors++; $display("FAIL stop_restart: got n=%0d addr=%0d lo=%h, required 2 0 44", n_issued, addr_log[0], lo_log[0]); end
    endtask

    task automatic test_wr_err();
        bit finished;
        write_mem(5'd0, 16'h0101);
        write_mem(5'd1, 16'hFFFF);
        core_pc = 5'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = 16'hDEAD;
        @(negedge clk);
        prog_we = 1'b0;
        checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_pulse: got %b, required 1", wr_err); end
        @(negedge clk);
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_width: got %b, required 0", wr_err); end
        finished = 1'b0;
        for (int c = 0; c < 30 && !finished; c++) begin
            @(negedge clk);
            if (done === 1'b1) finished = 1'b1;
        end
        checks++; if (!finished) begin errors++; $display("FAIL wr_err_run_done: got done=%b, required 1", done); end
        pc_seq[0] = 5'd1; pc_n = 1;
        run(40);
        checks++; if ({lo_log[0], hi_log[0]} !== {7'h01, 8'h01}) begin
            errors++; $display("FAIL wr_err_mem_kept: got %h %h, required 01 01", lo_log[0], hi_log[0]); end
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = 16'h0A7E;
        run(40);
        checks++; if ({lo_log[0], hi_log[0]} !== {7'h7E, 8'h0A}) begin
            errors++; $display("FAIL idle_write_start: got %h %h, required 7e 0a", lo_log[0], hi_log[0]); end
        checks++; if (wr_err_seen !== 0) begin errors++; $display("FAIL idle_write_err: got %0d, required 0", wr_err_seen); end
    endtask

    task automatic test_max_issue();
        int   cyc;
        int   hi3;
        logic prev;
        write_mem(5'd0, 16'h1357);
        core_pc = 5'd0; hi3 = 0; prev = 1'b0;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        cyc = 1;
        while (done3 !== 1'b1 && cyc < 60) begin
            if (load_en3 && prev) hi3++;
            prev = load_en3;
            @(negedge clk);
            cyc++;
        end
        checks++; if (done3 !== 1'b1 || cyc !== 17) begin
            errors++; $display("FAIL max_done: got done=%b cycle=%0d, required 1 17", done3, cyc); end
        checks++; if (hi3 !== 3 || icount3 !== 8'd3) begin
            errors++; $display("FAIL max_issued: got beats=%0d icount=%0d, required 3 3", hi3, icount3); end
    endtask

    task automatic test_rst_exec();
        bit   found;
        logic prev;
        core_pc = 5'd0; found = 1'b0; prev = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (load_en && prev) found = 1'b1;
            prev = load_en;
        end
        @(negedge clk);
        checks++; if (!found || icount !== 8'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_exec_reach: got found=%b icount=%0d busy=%b, required 1 1 1", found, icount, busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({load_en, lo_data, hi_data, fetch_addr, busy, done, icount, wr_err} !== 32'd0) begin
            errors++; $display("FAIL rst_exec_outputs: got %h, required 0", {load_en, lo_data, hi_data, fetch_addr, busy, done, icount, wr_err});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequential();
        test_branch();
        test_stop();
        test_wr_err();
        test_max_issue();
        test_rst_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
